spi_master_cfg: RTL

Parameterised SPI master: the next generation of the fixed 8-bit, single-mode master. It adds a configurable word width, all four SPI modes selected at run time, MSB- or LSB-first ordering, and multiple chip selects. It sits between the register/bus front-end (start/data handshake) and the SPI pins, and keeps the same start/busy/done contract.

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_clk_gen.sv | 48 ++++
 rtl/spi_master_cfg.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the configurable SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TRAIL = 2'd2
    } state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_cfg_t;

    // Width able to hold an sclk edge count of 0..2*data_w.
    function automatic int unsigned edge_cnt_w(input int unsigned data_w);
        return $clog2(2 * data_w + 1);
    endfunction

    function automatic int unsigned cs_w(input int unsigned num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Divides clk into sclk edge strobes while enabled; counters clear when disabled.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter  int unsigned CLK_DIV = 4,
    parameter  int unsigned DATA_W  = 8,
    localparam int unsigned EW      = edge_cnt_w(DATA_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          lead_edge_c,
    output logic          trail_edge_c,
    output logic [EW-1:0] edge_cnt
);

    localparam int unsigned DW = cnt_w(CLK_DIV);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [EW-1:0] edge_cnt_q, edge_cnt_d;
    logic          tick_c;

    // edge_cnt holds edges already produced; the strobed edge is edge_cnt+1.
    always_comb begin
        tick_c     = en && (div_cnt_q == DW'(CLK_DIV - 1));
        div_cnt_d  = '0;
        edge_cnt_d = '0;
        if (en) begin
            div_cnt_d  = tick_c ? '0 : div_cnt_q + DW'(1);
            edge_cnt_d = tick_c ? edge_cnt_q + EW'(1) : edge_cnt_q;
        end
        lead_edge_c  = tick_c && !edge_cnt_q[0];
        trail_edge_c = tick_c &&  edge_cnt_q[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;

endmodule

// File: rtl/spi_master_cfg.sv
// SPI master with run-time mode, bit order and chip-select choice; fixed word width.
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter  int unsigned DATA_W  = 8,
    parameter  int unsigned CLK_DIV = 4,
    parameter  int unsigned NUM_CS  = 2,
    localparam int unsigned CS_W    = cs_w(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int unsigned EW = edge_cnt_w(DATA_W);
    localparam int unsigned TW = cnt_w(CLK_DIV);

    state_e            state_q, state_d;
    spi_cfg_t          cfg_q, cfg_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic [TW-1:0]     trail_cnt_q, trail_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              sample_q, sample_d;

    logic              lead_edge_c, trail_edge_c;
    logic [EW-1:0]     edge_cnt;
    logic              last_edge_c, shift_edge_c, sample_edge_c, cs_ok_c;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) u_clk_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (state_q == SHIFT),
        .lead_edge_c  (lead_edge_c),
        .trail_edge_c (trail_edge_c),
        .edge_cnt     (edge_cnt)
    );

    // cpha=1 holds the first bit through edge 1; cpha=0 skips the shift on the closing edge.
    always_comb begin
        last_edge_c   = (edge_cnt == EW'(2 * DATA_W - 1));
        shift_edge_c  = cfg_q.cpha ? (lead_edge_c && (edge_cnt != '0))
                                   : (trail_edge_c && !last_edge_c);
        sample_edge_c = cfg_q.cpha ? trail_edge_c : lead_edge_c;
        cs_ok_c       = (32'(cs_sel) < NUM_CS);
    end

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        cs_n_d      = cs_n_q;
        trail_cnt_d = '0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sclk_d      = sclk_q;
        sample_d    = 1'b0;

        // miso is captured at the end of the cycle in which the sample edge appears on sclk.
        if (sample_q) begin
            rx_sh_d = cfg_q.lsb_first ? {miso, rx_sh_q[DATA_W-1:1]}
                                      : {rx_sh_q[DATA_W-2:0], miso};
        end

        case (state_q)
            IDLE: begin
                cfg_d.cpol = cpol;
                sclk_d     = cpol;
                if (start && cs_ok_c) begin
                    state_d         = SHIFT;
                    cfg_d.cpha      = cpha;
                    cfg_d.lsb_first = lsb_first;
                    tx_sh_d         = tx_data;
                    rx_sh_d         = '0;
                    busy_d          = 1'b1;
                    cs_n_d          = ~(NUM_CS'(1) << cs_sel);
                end
            end
            SHIFT: begin
                sample_d = sample_edge_c;
                if (lead_edge_c || trail_edge_c) begin
                    sclk_d = ~sclk_q;
                end
                if (shift_edge_c) begin
                    tx_sh_d = cfg_q.lsb_first ? (tx_sh_q >> 1) : (tx_sh_q << 1);
                end
                if (trail_edge_c && last_edge_c) begin
                    state_d = TRAIL;
                end
            end
            TRAIL: begin
                trail_cnt_d = trail_cnt_q + TW'(1);
                if (trail_cnt_q == TW'(CLK_DIV - 1)) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    cs_n_d    = '1;
                    rx_data_d = rx_sh_q;
                end
            end
            default: state_d = IDLE;
        endcase

        mosi_d = cfg_d.lsb_first ? tx_sh_d[0] : tx_sh_d[DATA_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            cs_n_q      <= '1;
            trail_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            sample_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            cs_n_q      <= cs_n_d;
            trail_cnt_q <= trail_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            sample_q    <= sample_d;
        end
    end

    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule
